// File: rtl/drive_pkg.sv
// Shared encodings for the wall-following autopilot: FSM states, detector bit
// positions and the command bit order packed into the TX byte.
package drive_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecide = 3'd1,
    StFwd    = 3'd2,
    StTurnL  = 3'd3,
    StTurnR  = 3'd4,
    StTurnBk = 3'd5,
    StSettle = 3'd6
  } drive_state_e;

  localparam int unsigned NumDet   = 4;
  localparam int unsigned DetFront = 0;
  localparam int unsigned DetBack  = 1;
  localparam int unsigned DetLeft  = 2;
  localparam int unsigned DetRight = 3;

  localparam int unsigned NumCmd   = 4;
  localparam int unsigned CmdFwd   = 0;
  localparam int unsigned CmdBack  = 1;
  localparam int unsigned CmdLeft  = 2;
  localparam int unsigned CmdRight = 3;

  // Command levels driven while resident in a state; never more than one bit set.
  function automatic logic [NumCmd-1:0] cmd_for_state(drive_state_e st);
    logic [NumCmd-1:0] cmd;
    cmd = '0;
    case (st)
      StFwd:            cmd[CmdFwd]   = 1'b1;
      StTurnL:          cmd[CmdLeft]  = 1'b1;
      StTurnR, StTurnBk: cmd[CmdRight] = 1'b1;
      default:          cmd = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear and terminal-count compare; done_o flags
// the last cycle of a length_i-cycle interval. Saturates instead of wrapping.
module cycle_timer #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            run_i,
  input  logic [CntW-1:0] length_i,
  output logic            done_o
);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i && (count_q != {CntW{1'b1}})) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = run_i && (count_q == (length_i - CntW'(1)));

endmodule

// File: rtl/auto_drive_ctrl.sv
// Right-hand wall-following sequencer: registers the car's detector bits and
// drives time-sliced move/turn command levels toward the UART link.
module auto_drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned MOVE_CYCLES   = 100_000_000,
  parameter int unsigned TURN_CYCLES   = 90_000_000,
  parameter int unsigned SETTLE_CYCLES = 20_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       front_detector,
  input  logic       back_detector,
  input  logic       left_detector,
  input  logic       right_detector,
  output logic       move_forward,
  output logic       move_backward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       busy,
  output logic [2:0] state_o
);

  drive_state_e      state_d, state_q;
  logic              just_turned_d, just_turned_q;
  logic [NumDet-1:0] det_d, det_q;
  logic [NumCmd-1:0] cmd_d, cmd_q;
  logic              busy_d, busy_q;

  logic              timer_clear, timer_run, timer_done;
  logic [CNT_W-1:0]  timer_len;
  logic              unused_det_back;

  always_comb begin
    det_d           = '0;
    det_d[DetFront] = front_detector;
    det_d[DetBack]  = back_detector;
    det_d[DetLeft]  = left_detector;
    det_d[DetRight] = right_detector;
  end

  // Rear detector is status only; it never feeds a decision.
  assign unused_det_back = det_q[DetBack];

  always_comb begin
    timer_len = CNT_W'(1);
    timer_run = 1'b0;
    case (state_q)
      StFwd: begin
        timer_len = CNT_W'(MOVE_CYCLES);
        timer_run = 1'b1;
      end
      StTurnL, StTurnR: begin
        timer_len = CNT_W'(TURN_CYCLES);
        timer_run = 1'b1;
      end
      StTurnBk: begin
        timer_len = CNT_W'(2 * TURN_CYCLES);
        timer_run = 1'b1;
      end
      StSettle: begin
        timer_len = CNT_W'(SETTLE_CYCLES);
        timer_run = 1'b1;
      end
      default: begin
        timer_len = CNT_W'(1);
        timer_run = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    just_turned_d = just_turned_q;

    unique case (state_q)
      StIdle: begin
        state_d = StDecide;
      end
      StDecide: begin
        if (!det_q[DetRight] && !just_turned_q) begin
          state_d = StTurnR;
        end else if (!det_q[DetFront]) begin
          state_d = StFwd;
        end else if (!det_q[DetLeft]) begin
          state_d = StTurnL;
        end else begin
          state_d = StTurnBk;
        end
      end
      StFwd: begin
        if (det_q[DetFront] || timer_done) begin
          state_d = StSettle;
        end
      end
      StTurnL, StTurnR, StTurnBk: begin
        if (timer_done) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (timer_done) begin
          state_d = StDecide;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A forward step re-arms right turns; any turn blocks the next one.
    if (state_d != state_q) begin
      if (state_d == StFwd) begin
        just_turned_d = 1'b0;
      end else if ((state_d == StTurnL) || (state_d == StTurnR) || (state_d == StTurnBk)) begin
        just_turned_d = 1'b1;
      end
    end

    if (!enable) begin
      state_d       = StIdle;
      just_turned_d = 1'b0;
    end
  end

  assign timer_clear = (state_d != state_q);

  cycle_timer #(
    .CntW(CNT_W)
  ) u_cycle_timer (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .clear_i (timer_clear),
    .run_i   (timer_run),
    .length_i(timer_len),
    .done_o  (timer_done)
  );

  // Outputs are decoded from the next state so the registered levels line up
  // with the state they belong to.
  always_comb begin
    cmd_d  = cmd_for_state(state_d);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      just_turned_q <= 1'b0;
      det_q         <= '0;
      cmd_q         <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      just_turned_q <= just_turned_d;
      det_q         <= det_d;
      cmd_q         <= cmd_d;
      busy_q        <= busy_d;
    end
  end

  assign move_forward  = cmd_q[CmdFwd];
  assign move_backward = cmd_q[CmdBack];
  assign turn_left     = cmd_q[CmdLeft];
  assign turn_right    = cmd_q[CmdRight];
  assign busy          = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_auto_drive_ctrl.sv
// Self-checking bench for auto_drive_ctrl: table of decision vectors, directed
// corner sequences and a long random run against a countdown reference model.
module tb_auto_drive_ctrl;

  localparam int MOVE   = 3;
  localparam int TURN   = 4;
  localparam int SETTLE = 2;

  localparam int S_IDLE = 0, S_DECIDE = 1, S_FWD = 2, S_TL = 3, S_TR = 4, S_TBK = 5, S_SETTLE = 6;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b1;
  logic       enable  = 1'b0;
  logic       fd = 1'b0, bd = 1'b0, ld = 1'b0, rd = 1'b0;
  logic       move_forward, move_backward, turn_left, turn_right, busy;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current activity plus cycles remaining in it.
  int   m_state, m_rem, m_jt;
  logic m_f, m_l, m_r;

  auto_drive_ctrl #(
    .MOVE_CYCLES  (MOVE),
    .TURN_CYCLES  (TURN),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (32)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .front_detector(fd),
    .back_detector (bd),
    .left_detector (ld),
    .right_detector(rd),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .turn_left     (turn_left),
    .turn_right    (turn_right),
    .busy          (busy),
    .state_o       (state_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", state_o);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int duration(input int s);
    case (s)
      S_FWD:         return MOVE;
      S_TL, S_TR:    return TURN;
      S_TBK:         return 2 * TURN;
      S_SETTLE:      return SETTLE;
      default:       return 0;
    endcase
  endfunction

  task automatic enter(input int s);
    m_state = s;
    m_rem   = duration(s);
    if (s == S_FWD) m_jt = 0;
    if (s == S_TL || s == S_TR || s == S_TBK) m_jt = 1;
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_rem   = 0;
    m_jt    = 0;
    m_f     = 1'b0;
    m_l     = 1'b0;
    m_r     = 1'b0;
  endtask

  task automatic model_step();
    if (!enable) begin
      m_state = S_IDLE;
      m_jt    = 0;
    end else begin
      case (m_state)
        S_IDLE:   m_state = S_DECIDE;
        S_DECIDE: begin
          if (!m_r && m_jt == 0) enter(S_TR);
          else if (!m_f)         enter(S_FWD);
          else if (!m_l)         enter(S_TL);
          else                   enter(S_TBK);
        end
        S_SETTLE: begin
          m_rem--;
          if (m_rem == 0) m_state = S_DECIDE;
        end
        default: begin
          m_rem--;
          if (m_rem == 0 || (m_state == S_FWD && m_f)) enter(S_SETTLE);
        end
      endcase
    end
    m_f = fd;
    m_l = ld;
    m_r = rd;
  endtask

  task automatic compare_model();
    logic [3:0] exp_cmd;
    exp_cmd = {m_state == S_FWD, 1'b0, m_state == S_TL, m_state == S_TR || m_state == S_TBK};
    check("state", 32'(state_o), 32'(m_state));
    check("cmds", 32'({move_forward, move_backward, turn_left, turn_right}), 32'(exp_cmd));
    check("busy", 32'(busy), 32'(m_state != S_IDLE));
    check("onehot", 32'($countones({move_forward, move_backward, turn_left, turn_right}) <= 1), 1);
    check("backward_zero", 32'(move_backward), 0);
    check("busy_vs_state", 32'(busy), 32'(state_o != 3'd0));
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({move_forward, move_backward, turn_left, turn_right, busy, state_o}), 0);
  endtask

  // May be called at any point away from a clock edge; ends just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_async");
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check_all_zero("reset_held");
    rst_n = 1'b1;
  endtask

  function automatic logic level_of(input int s);
    case (s)
      S_FWD:        return move_forward;
      S_TL:         return turn_left;
      S_TR, S_TBK:  return turn_right;
      default:      return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic f;
    logic b;
    logic l;
    logic r;
    int   exp_state;
    int   exp_len;
  } vec_t;

  vec_t vecs[6];
  int   seq1[15];

  initial begin
    vecs[0] = '{f: 1'b0, b: 1'b0, l: 1'b0, r: 1'b0, exp_state: S_TR,  exp_len: 4};
    vecs[1] = '{f: 1'b0, b: 1'b1, l: 1'b0, r: 1'b1, exp_state: S_FWD, exp_len: 3};
    vecs[2] = '{f: 1'b1, b: 1'b0, l: 1'b0, r: 1'b1, exp_state: S_TL,  exp_len: 4};
    vecs[3] = '{f: 1'b1, b: 1'b1, l: 1'b1, r: 1'b1, exp_state: S_TBK, exp_len: 8};
    vecs[4] = '{f: 1'b1, b: 1'b0, l: 1'b1, r: 1'b1, exp_state: S_TBK, exp_len: 8};
    vecs[5] = '{f: 1'b0, b: 1'b0, l: 1'b1, r: 1'b1, exp_state: S_FWD, exp_len: 3};

    seq1 = '{S_DECIDE, S_TR, S_TR, S_TR, S_TR, S_SETTLE, S_SETTLE, S_DECIDE,
             S_FWD, S_FWD, S_FWD, S_SETTLE, S_SETTLE, S_DECIDE, S_TR};

    model_reset();
    #2;

    // Open space after reset: turn right, settle, step forward, turn right again.
    enable = 1'b1;
    {fd, bd, ld, rd} = 4'b0000;
    do_reset();
    check("seq1_idle", 32'(state_o), S_IDLE);
    for (int i = 0; i < 15; i++) begin
      cycle();
      check("seq1_state", 32'(state_o), 32'(seq1[i]));
    end

    // Decision table: first motion chosen and how long its command stays high.
    foreach (vecs[i]) begin
      int len;
      enable = 1'b1;
      {fd, bd, ld, rd} = {vecs[i].f, vecs[i].b, vecs[i].l, vecs[i].r};
      do_reset();
      cycle();
      cycle();
      check("vec_state", 32'(state_o), 32'(vecs[i].exp_state));
      len = level_of(vecs[i].exp_state) ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
        cycle();
        if (level_of(vecs[i].exp_state)) len++;
        else break;
      end
      check("vec_len", 32'(len), 32'(vecs[i].exp_len));
      check("vec_after", 32'(state_o), S_SETTLE);
    end

    // Obstacle appears during the first forward cycle: step cut short.
    enable = 1'b1;
    {fd, bd, ld, rd} = 4'b0001;
    do_reset();
    cycle();
    cycle();
    check("abort_fwd", 32'(state_o), S_FWD);
    fd = 1'b1;
    cycle();
    check("abort_still_fwd", 32'({state_o, move_forward}), 32'({3'(S_FWD), 1'b1}));
    cycle();
    check("abort_settle", 32'({state_o, move_forward}), 32'({3'(S_SETTLE), 1'b0}));

    // Drop enable in each cycle of a right turn, including the expiry cycle.
    for (int j = 1; j <= TURN; j++) begin
      enable = 1'b1;
      {fd, bd, ld, rd} = 4'b0000;
      do_reset();
      cycle();
      cycle();
      for (int k = 1; k < j; k++) cycle();
      check("abort_tr_in", 32'(state_o), S_TR);
      enable = 1'b0;
      cycle();
      check_all_zero("abort_idle");
      cycle();
      check_all_zero("abort_idle_hold");
      enable = 1'b1;
      cycle();
      check("reenable_decide", 32'(state_o), S_DECIDE);
      cycle();
      check("reenable_tr", 32'(state_o), S_TR);
    end

    // Long random run against the model.
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      fd     = ($urandom_range(0, 99) < 40);
      bd     = $urandom_range(0, 1);
      ld     = ($urandom_range(0, 99) < 50);
      rd     = ($urandom_range(0, 99) < 60);
      enable = ($urandom_range(0, 99) != 0);
      cycle();
    end

    // Asynchronous reset while a command is active.
    begin
      bit hit;
      hit    = 1'b0;
      enable = 1'b1;
      {fd, bd, ld, rd} = 4'b0000;
      for (int k = 0; k < 50 && !hit; k++) begin
        cycle();
        hit = move_forward | turn_left | turn_right;
      end
      check("motion_seen", 32'(hit), 1);
      #2;
      do_reset();
      check("post_reset_idle", 32'(state_o), S_IDLE);
      cycle();
      cycle();
      check("post_reset_tr", 32'(state_o), S_TR);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
